// File: rtl/grng_seq_ctrl.sv
// Sequencing controller for a buffered Gaussian RNG datapath.
// Loads seed words, fills the pipeline, then streams samples.
//
// Ports:
//   clk, rst         - rising-edge clock, async active-high reset
//   start, stop      - begin a run (IDLE only) / abort a run
//   num_samples      - run length latched at start, 0 = unlimited
//   seed_in/valid    - host seed word handshake (seed_ready back)
//   seed_load/sel/   - seed register write strobe, index and data
//   seed_data          towards the datapath
//   pipe_en          - clock enable for all datapath buffer stages
//   out_valid/ready  - sample handshake with downstream
//   busy, done       - activity flag and one-cycle end-of-run pulse
//   sample_cnt       - samples transferred in the current/last run
module grng_seq_ctrl #(
    parameter int LATENCY    = 4,
    parameter int SEED_WORDS = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [31:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    output logic             seed_load,
    output logic [1:0]       seed_sel,
    output logic [31:0]      seed_data,
    output logic             pipe_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0]       SEED_LAST = 2'(SEED_WORDS - 1);
    localparam logic [7:0]       FILL_LAST = 8'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       fill_q, fill_d;
    logic             xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        fill_d     = fill_q;
        seed_ready = 1'b0;
        seed_load  = 1'b0;
        pipe_en    = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = num_samples;
                    cnt_d   = '0;
                    idx_d   = '0;
                    fill_d  = '0;
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                seed_ready = 1'b1;
                seed_load  = seed_valid;
                if (stop) begin
                    state_d = S_DONE;
                end else if (seed_valid) begin
                    if (idx_q == SEED_LAST) begin
                        fill_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_FILL: begin
                pipe_en = 1'b1;
                if (stop) begin
                    state_d = S_DONE;
                end else if (fill_q == FILL_LAST) begin
                    fill_d  = '0;
                    state_d = S_RUN;
                end else begin
                    fill_d = fill_q + 8'd1;
                end
            end
            S_RUN: begin
                out_valid = 1'b1;
                // Stalling the pipe keeps the presented sample stable.
                pipe_en   = out_ready;
                xfer      = out_ready;
                if (xfer && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_inc;
                end
                if (stop) begin
                    state_d = S_DONE;
                end else if (xfer && n_q != '0 && cnt_inc == n_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign seed_sel   = idx_q;
    assign seed_data  = seed_ready ? seed_in : 32'd0;
    assign busy       = (state_q != S_IDLE);
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_grng_seq_ctrl.sv
// Self-checking bench for grng_seq_ctrl: timeline reference
// model with directed and randomized runs plus a narrow-counter DUT.
module tb_grng_seq_ctrl;

    localparam int LAT = 4;
    localparam int SW  = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop;
    logic [CW-1:0] num_samples;
    logic [31:0]   seed_in;
    logic          seed_valid, seed_ready, seed_load;
    logic [1:0]    seed_sel;
    logic [31:0]   seed_data;
    logic          pipe_en, out_valid, out_ready;
    logic          busy, done;
    logic [CW-1:0] sample_cnt;

    logic          start_s, stop_s;
    logic          seed_ready_s, seed_load_s;
    logic [1:0]    seed_sel_s;
    logic [31:0]   seed_data_s;
    logic          pipe_en_s, out_valid_s, busy_s, done_s;
    logic [2:0]    sample_cnt_s;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    grng_seq_ctrl #(.LATENCY(LAT), .SEED_WORDS(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num_samples(num_samples), .seed_in(seed_in),
        .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed_load(seed_load), .seed_sel(seed_sel),
        .seed_data(seed_data), .pipe_en(pipe_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    grng_seq_ctrl #(.LATENCY(2), .SEED_WORDS(1), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .stop(stop_s),
        .num_samples(3'd0), .seed_in(32'd0),
        .seed_valid(1'b1), .seed_ready(seed_ready_s),
        .seed_load(seed_load_s), .seed_sel(seed_sel_s),
        .seed_data(seed_data_s), .pipe_en(pipe_en_s),
        .out_valid(out_valid_s), .out_ready(1'b1),
        .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s)
    );

    always @(negedge clk) if (done) done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run. vmode<0: seed_valid alternates 1,0,1,...
    // rmode<0: out_ready low on run cycles 1..4. stop_at>0: stop
    // raised together with the stop_at-th transfer.
    task automatic run(input int n, input int stop_at,
                       input int vmode, input int rmode);
        int got, xf, c, d0;
        logic fin;
        d0 = done_seen;
        num_samples = CW'(n);
        start = 1'b1;
        stop = 1'($urandom_range(1));
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pipe", pipe_en, 0);
        tick();
        start = 1'b0;
        stop = 1'b0;
        got = 0;
        c = 0;
        while (got < SW) begin
            if (vmode < 0) seed_valid = (c % 2 == 0);
            else seed_valid = ($urandom_range(99) < vmode) || c > 50;
            seed_in = $urandom;
            @(negedge clk);
            chk("seed_ready", seed_ready, 1);
            chk("seed_load", seed_load, seed_valid);
            chk("seed_pipe", pipe_en, 0);
            if (seed_valid) begin
                chk("seed_sel", seed_sel, got);
                chk("seed_data", seed_data, seed_in);
                got++;
            end
            c++;
            tick();
        end
        seed_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            out_ready = 1'($urandom_range(1));
            start = 1'($urandom_range(1));
            @(negedge clk);
            chk("fill_pipe", pipe_en, 1);
            chk("fill_valid", out_valid, 0);
            chk("fill_sready", seed_ready, 0);
            chk("fill_cnt", sample_cnt, 0);
            tick();
        end
        xf = 0;
        c = 0;
        fin = 1'b0;
        while (!fin) begin
            start = 1'($urandom_range(1));
            if (rmode < 0) out_ready = !(c >= 1 && c <= 4);
            else out_ready = ($urandom_range(99) < rmode) || c > 500;
            stop = (stop_at > 0 && xf == stop_at - 1);
            if (stop) out_ready = 1'b1;
            @(negedge clk);
            chk("run_valid", out_valid, 1);
            chk("run_pipe", pipe_en, out_ready);
            chk("run_cnt", sample_cnt, xf);
            chk("run_done", done, 0);
            if (out_ready) xf++;
            c++;
            tick();
            if (stop || (n != 0 && xf == n)) fin = 1'b1;
        end
        start = 1'b0;
        stop = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_pipe", pipe_en, 0);
        chk("done_cnt", sample_cnt, xf);
        tick();
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_cnt", sample_cnt, xf);
        tick();
        chk("done_once", done_seen, d0 + 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        num_samples = '0;
        seed_in = '0;
        seed_valid = 1'b0;
        out_ready = 1'b0;
        start_s = 1'b0;
        stop_s = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_pipe", pipe_en, 0);
        chk("rst_sready", seed_ready, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b0;

        run(5, 0, 100, 100);
        run(2, 0, -1, 100);
        run(3, 0, 100, -1);
        run(0, 7, 100, 70);
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) run(0, $urandom_range(1, 9), 60, 60);
            else run($urandom_range(1, 12), 0, 50, 60);
        end

        // abort from FILL via stop
        num_samples = CW'(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        seed_valid = 1'b1;
        for (int i = 0; i < SW; i++) tick();
        seed_valid = 1'b0;
        tick();
        stop = 1'b1;
        @(negedge clk);
        chk("abort_pipe", pipe_en, 1);
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("abort_done", done, 1);
        chk("abort_cnt", sample_cnt, 0);
        tick();
        @(negedge clk);
        chk("abort_idle", busy, 0);
        tick();

        // reset in FILL: asynchronous clear, no done pulse
        num_samples = CW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        seed_valid = 1'b1;
        for (int i = 0; i < SW; i++) tick();
        seed_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("pre_rst_pipe", pipe_en, 1);
        begin
            int d0;
            d0 = done_seen;
            #1 rst = 1'b1;
            #1;
            chk("arst_pipe", pipe_en, 0);
            chk("arst_busy", busy, 0);
            chk("arst_valid", out_valid, 0);
            chk("arst_sload", seed_load, 0);
            chk("arst_done", done, 0);
            chk("arst_sel", seed_sel, 0);
            tick();
            rst = 1'b0;
            tick();
            tick();
            chk("arst_idle", busy, 0);
            chk("arst_nodone", done_seen, d0);
        end
        run(4, 0, 100, 100);

        // narrow counter saturates at all-ones
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sat_valid", out_valid_s, 1);
            chk("sat_cnt", sample_cnt_s, (i > 7) ? 7 : i);
            tick();
        end
        stop_s = 1'b1;
        @(negedge clk);
        chk("sat_hold", sample_cnt_s, 7);
        tick();
        stop_s = 1'b0;
        @(negedge clk);
        chk("sat_done", done_s, 1);
        chk("sat_final", sample_cnt_s, 7);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
